fetch: RTL

Instruction-fetch stage. It produces FetchData_IF, the instruction word that decode consumes combinationally. The block owns the PC and issues in-order word reads to instruction memory over a request/response handshake, with up to MAX_OUT reads outstanding. Returned instructions are buffered in a small FIFO, and the block redirects on decode jumps and execute-resolved branches, discarding wrong-path words. There are no delay slots.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   NOP_INSTR         : word presented to decode when no instruction is valid
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   fetch_entry_t     : one buffered instruction with its PC+4
//   jump_target()     : J/JAL target from the jump's PC+4 and its 26-bit instr_index
package mips_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                              input logic [25:0] instr_index);
    return {pcplus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the imem response path and decode.
// Synchronous FIFO of fetch entries; flush has priority over push and pop.
// Push into a full FIFO is honoured when a pop happens in the same cycle.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i/wdata_i : write an entry at the tail
//   pop_i          : drop the head entry (ignored when empty)
//   flush_i        : discard all entries
//   count_o        : number of entries held
//   head_o         : oldest entry (undefined when count_o == 0)
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  fetch_entry_t    wdata_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t    head_o
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && !flush_i && ((count_q != DepthC) || do_pop);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      // Depth is a power of two, so pointers wrap by plain overflow.
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage. Owns the fetch PC, issues in-order word reads to
// instruction memory (up to MAX_OUT outstanding), buffers returned words and
// presents the head to decode. Redirects on decode jumps and EX branches,
// dropping wrong-path responses via a kill counter.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   AnyStall                      : decode not accepting this cycle
//   Jump_ID, JumpTgt_ID           : head is J/JAL with this instr_index
//   BranchTaken_EX, BranchTgt_EX  : taken branch in EX and its target
//   ImemReq_IF, ImemAddr_IF       : read request (from registered state)
//   ImemRdy                       : memory accepts the request
//   ImemVld, ImemData             : in-order read response
//   FetchData_IF, PCPlus4_IF      : head instruction and its PC+4 (0 if invalid)
//   Valid_IF                      : head holds a real instruction
module fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        Jump_ID,
  input  logic [25:0] JumpTgt_ID,
  input  logic        BranchTaken_EX,
  input  logic [31:0] BranchTgt_EX,
  output logic        ImemReq_IF,
  output logic [31:0] ImemAddr_IF,
  input  logic        ImemRdy,
  input  logic        ImemVld,
  input  logic [31:0] ImemData,
  output logic [31:0] FetchData_IF,
  output logic [31:0] PCPlus4_IF,
  output logic        Valid_IF
);

  localparam int unsigned   CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthC  = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] MaxOutC = CntW'(MAX_OUT);

  logic [31:0]     fpc_q, fpc_d;    // next address to request
  logic [31:0]     rpc_q, rpc_d;    // PC of the next response to be kept
  logic [CntW-1:0] out_q, out_d;    // reads issued, response not yet seen
  logic [CntW-1:0] kill_q, kill_d;  // outstanding reads that are wrong-path

  logic [CntW-1:0] fifo_count;
  fetch_entry_t    fifo_head, push_entry;
  logic [CntW:0]   occupancy;
  logic            req, accept, resp, resp_drop, push, pop;
  logic            take_jump, redirect;
  logic [31:0]     target;
  logic            unused_tgt_lsb;

  assign unused_tgt_lsb = ^BranchTgt_EX[1:0];

  // Killed reads will never land in the FIFO, so they do not reserve space.
  assign occupancy = {1'b0, fifo_count} + {1'b0, out_q - kill_q};

  assign req         = !reset && (out_q < MaxOutC) && (occupancy < DepthC);
  assign ImemReq_IF  = req;
  assign ImemAddr_IF = fpc_q;

  assign Valid_IF     = !reset && (fifo_count != '0);
  assign FetchData_IF = Valid_IF ? fifo_head.instr : NOP_INSTR;
  assign PCPlus4_IF   = Valid_IF ? fifo_head.pcplus4 : 32'h0;

  always_comb begin
    accept    = req && ImemRdy;
    resp      = ImemVld && (out_q != '0);
    pop       = Valid_IF && !AnyStall;
    // A taken branch is older than the head, so it wins over a jump.
    take_jump = Jump_ID && pop && !BranchTaken_EX;
    redirect  = BranchTaken_EX || take_jump;
    target    = BranchTaken_EX ? {BranchTgt_EX[31:2], 2'b00}
                               : jump_target(PCPlus4_IF, JumpTgt_ID);
    resp_drop = resp && ((kill_q != '0) || redirect);
    push      = resp && !resp_drop;

    out_d = out_q + CntW'(accept) - CntW'(resp);

    kill_d = kill_q;
    if (redirect) begin
      // Everything still in flight after this cycle is on the wrong path,
      // including a request accepted right now.
      kill_d = out_d;
    end else if (resp && (kill_q != '0)) begin
      kill_d = kill_q - CntW'(1);
    end

    fpc_d = fpc_q;
    if (redirect)    fpc_d = target;
    else if (accept) fpc_d = fpc_q + 32'd4;

    rpc_d = rpc_q;
    if (redirect)  rpc_d = target;
    else if (push) rpc_d = rpc_q + 32'd4;
  end

  assign push_entry = '{pcplus4: rpc_q + 32'd4, instr: ImemData};

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q  <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      kill_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      kill_q <= kill_d;
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .flush_i(redirect),
    .count_o(fifo_count),
    .head_o (fifo_head)
  );

endmodule
